// File: rtl/jt900h_ram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : jt900h_ram_resp
//  Purpose  : Memory-side responder for the jt900h CPU RAM bus. Serves 16-bit
//             word reads and byte-lane writes from a local synchronous RAM,
//             inserting WAIT programmable wait states before a one-cycle
//             ram_rdy pulse. Reads outside the RAM window return OPENBUS.
//  Revision : 1.0 - initial release
// ============================================================================
module jt900h_ram_resp #(
    parameter int          AW      = 9,
    parameter int          WAIT    = 2,
    parameter logic [23:0] BASE    = 24'h0,
    parameter logic [15:0] OPENBUS = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [23:0] ram_addr,
    input  logic        ram_cs,
    input  logic        ram_we,
    input  logic [1:0]  ram_dsn,
    input  logic [15:0] ram_din,
    output logic [15:0] ram_dout,
    output logic        ram_rdy
);

    // Window end is computed one bit wider so BASE near the top of the
    // 24-bit space cannot wrap around and alias low addresses.
    localparam logic [24:0] c_win_end = {1'b0, BASE} + (25'd1 << (AW + 1));
    localparam logic [3:0]  c_wait    = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [23:0]   r_addr;
    logic          r_we;
    logic [1:0]    r_dsn;
    logic [15:0]   r_din;
    logic          r_served;   // last access acked; same address must not re-trigger
    logic [15:0]   r_q;        // RAM result register, copied to ram_dout on ack
    logic [15:0]   r_mem [0:(2**AW)-1];

    logic          w_in_win;
    logic [AW-1:0] w_idx;
    logic [15:0]   w_word;
    logic [15:0]   w_merged;
    logic          w_addr_chg;
    logic          w_accept;
    logic          w_commit;

    // Address decode, lane merge and handshake qualifiers
    always_comb begin
        w_in_win   = ({1'b0, r_addr} >= {1'b0, BASE}) && ({1'b0, r_addr} < c_win_end);
        w_idx      = r_addr[AW:1];
        w_word     = r_mem[w_idx];
        w_merged   = { r_dsn[1] ? w_word[15:8] : r_din[15:8],
                       r_dsn[0] ? w_word[7:0]  : r_din[7:0] };
        w_addr_chg = (ram_addr != r_addr);
        w_accept   = ram_cs && !ram_rdy && !(r_served && !w_addr_chg);
        // The RAM operation fires on the last wait cycle, unless the access is
        // being aborted or restarted on that same edge.
        w_commit   = cen && (r_state == ST_WAIT) && ram_cs && !w_addr_chg &&
                     (r_cnt == 4'd0);
    end

    // Local RAM write port: only committed in-window writes touch the array
    always_ff @(posedge clk) begin
        if (w_commit && r_we && w_in_win) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // RAM result register: read word, post-write word, or open bus
    always_ff @(posedge clk) begin
        if (w_commit) begin
            if (!w_in_win) begin
                r_q <= OPENBUS;
            end else if (r_we) begin
                r_q <= w_merged;
            end else begin
                r_q <= w_word;
            end
        end
    end

    // Access sequencer: accept, count wait states, abort/restart, acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 24'd0;
            r_we     <= 1'b0;
            r_dsn    <= 2'b11;
            r_din    <= 16'd0;
            r_served <= 1'b0;
            ram_rdy  <= 1'b0;
            ram_dout <= 16'd0;
        end else if (cen) begin
            ram_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_served && (!ram_cs || w_addr_chg)) begin
                        r_served <= 1'b0;
                    end
                    if (w_accept) begin
                        r_addr   <= ram_addr;
                        r_we     <= ram_we;
                        r_dsn    <= ram_dsn;
                        r_din    <= ram_din;
                        r_cnt    <= c_wait;
                        r_served <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!ram_cs) begin
                        r_state <= ST_IDLE;
                    end else if (w_addr_chg) begin
                        r_addr <= ram_addr;
                        r_we   <= ram_we;
                        r_dsn  <= ram_dsn;
                        r_din  <= ram_din;
                        r_cnt  <= c_wait;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    ram_rdy  <= 1'b1;
                    ram_dout <= r_q;
                    r_served <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
